// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//   Digit-serial adder. Accepts an operand set {a, b, cin} on a valid/ready
//   handshake and adds DIGIT bits per clock, LSB digit first. After
//   N = WIDTH/DIGIT clocks it presents {cout, sum} = a + b + cin. The result is
//   held until the consumer takes it.
//
//   Optional feature macro: SERIAL_ADDER_SUB_EN
//     When defined, an extra input 'sub' is captured with the operands. With
//     sub=1 the block computes a + ~b + 1 and ignores cin, so cout=1 means no
//     borrow. When undefined, the 'sub' port is absent and the block only adds.
//
//   Reset is synchronous and active-low. It is sampled on the rising edge of
//   clk and overrides every other event.
// -----------------------------------------------------------------------------
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    // Number of digit steps per operation, and the counter width that spans them.
    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    // Stop elaboration on a bad shape. Without this check, a bad WIDTH/DIGIT
    // would silently drop the upper bits.
    if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
        $error("serial_adder: WIDTH must be a positive multiple of DIGIT");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] a_sr;        // addend A, shifted right one digit per step
    logic [WIDTH-1:0] b_sr;        // addend B (or ~B when subtracting), same shifting
    logic             carry;       // carry between digit steps
    logic [CNT_W-1:0] cnt;         // digit index within the current operation
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;

    logic             accept;      // operand handshake completes on this edge
    logic             last_digit;  // this RUN edge processes the final digit
    logic [WIDTH-1:0] b_load;      // B as it enters the shift register
    logic             c_load;      // initial carry for the operation
    logic [DIGIT-1:0] d_sum;       // sum bits of the current digit
    logic [DIGIT:0]   chain;       // ripple carry through the digit's cells
    logic [WIDTH-1:0] sum_next;

    assign accept     = in_valid && in_ready;
    assign last_digit = (cnt == CNT_W'(N - 1));

    // Subtraction reuses the adder: a - b = a + ~b + 1. The operand is inverted
    // and the carry is forced to 1 on capture, so the datapath itself is the same.
`ifdef SERIAL_ADDER_SUB_EN
    assign b_load = sub ? ~b : b;
    assign c_load = sub ? 1'b1 : cin;
`else
    assign b_load = b;
    assign c_load = cin;
`endif

    // One full-adder cell per bit of the digit, rippling from the carry flop.
    assign chain[0] = carry;
    for (genvar i = 0; i < DIGIT; i++) begin : g_fa
        assign d_sum[i]     = a_sr[i] ^ b_sr[i] ^ chain[i];
        assign chain[i + 1] = (a_sr[i] & b_sr[i]) | (chain[i] & (a_sr[i] ^ b_sr[i]));
    end

    // Each new digit enters at the top of the sum register while older digits
    // move down. After N steps the first digit computed is the LSB digit.
    assign sum_next = (sum_r >> DIGIT) | (WIDTH'(d_sum) << (WIDTH - DIGIT));

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: every clocked assignment is non-blocking, so all flops sample
        // their inputs from before the edge, whatever the statement order.
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and the handshake/status outputs, all decoded from state.
    always_comb begin
        // NOTE: every output gets a default first. An assignment missing on any
        // path through the case would otherwise infer a latch.
        state_next = state;
        in_ready   = 1'b0;
        busy       = 1'b0;
        out_valid  = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_digit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand shift registers: load on accept, then consume one digit per RUN edge.
    always_ff @(posedge clk) begin
        // NOTE: these registers are deliberately not reset. Their contents matter
        // only after an accept reloads them. The state register guards every use.
        if (accept) begin
            a_sr <= a;
            b_sr <= b_load;
        end else if (state == RUN) begin
            a_sr <= a_sr >> DIGIT;
            b_sr <= b_sr >> DIGIT;
        end
    end

    // Carry flop, digit counter and the result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            carry  <= 1'b0;
            cnt    <= '0;
            sum_r  <= '0;
            cout_r <= 1'b0;
        end else if (accept) begin
            carry <= c_load;
            cnt   <= '0;
        end else if (state == RUN) begin
            carry <= chain[DIGIT];
            cnt   <= cnt + CNT_W'(1);
            sum_r <= sum_next;
            if (last_digit) begin
                cout_r <= chain[DIGIT];
            end
        end
    end

    assign sum  = sum_r;
    assign cout = cout_r;

endmodule

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
//   Drives two serial_adder instances: WIDTH=8 with DIGIT=1, and WIDTH=8 with
//   DIGIT=4. The two share a clock and a reset. Expected results come from plain
//   integer arithmetic on the operands. Expected latency is WIDTH/DIGIT.
//   Define SERIAL_ADDER_SUB_EN for both the RTL and this bench to include the
//   subtract cases.
// -----------------------------------------------------------------------------
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid  [2];
    logic       in_ready  [2];
    logic [7:0] a         [2];
    logic [7:0] b         [2];
    logic       cin       [2];
`ifdef SERIAL_ADDER_SUB_EN
    logic       sub       [2];
`endif
    logic       out_valid [2];
    logic       out_ready [2];
    logic [7:0] sum       [2];
    logic       cout      [2];
    logic       busy      [2];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8), .DIGIT(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .a(a[0]), .b(b[0]), .cin(cin[0]),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub[0]),
`endif
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .sum(sum[0]), .cout(cout[0]), .busy(busy[0])
    );

    serial_adder #(.WIDTH(8), .DIGIT(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .a(a[1]), .b(b[1]), .cin(cin[1]),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub[1]),
`endif
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .sum(sum[1]), .cout(cout[1]), .busy(busy[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge. Outputs are sampled there and
    // new inputs are driven there.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction on instance idx. It checks latency, the RUN flags and
    // the result, then holds out_ready low for 'stall' cycles and checks that the
    // result is held. Finally it checks the handoff and the idle behaviour.
    task automatic do_op(input int idx, input logic [7:0] av, input logic [7:0] bv,
                         input logic cv, input logic sv, input int stall);
        int         n_exp;
        int         lat;
        bit         run_ok;
        bit         hold_ok;
        logic [8:0] exp;
        n_exp = (idx == 0) ? 8 : 2;
        if (sv)
            exp = {1'b0, av} + {1'b0, ~bv} + 9'd1;
        else
            exp = {1'b0, av} + {1'b0, bv} + {8'd0, cv};

        check("idle_in_ready", 32'(in_ready[idx]), 32'd1);
        a[idx] = av; b[idx] = bv; cin[idx] = cv; in_valid[idx] = 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
        sub[idx] = sv;
`endif
        tick();

        // RUN: scramble the inputs, issue stray in_valid/out_ready, and expect no effect.
        lat = 0;
        run_ok = 1'b1;
        while (!out_valid[idx] && lat < 50) begin
            if (!busy[idx] || in_ready[idx]) run_ok = 1'b0;
            a[idx] = 8'($urandom); b[idx] = 8'($urandom); cin[idx] = 1'($urandom);
            in_valid[idx] = 1'($urandom); out_ready[idx] = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
            sub[idx] = 1'($urandom);
`endif
            tick();
            lat++;
        end
        in_valid[idx] = 1'b0;
        out_ready[idx] = 1'b0;
        check("run_flags", 32'(run_ok), 32'd1);
        check("latency", 32'(lat), 32'(n_exp));
        check("sum", 32'(sum[idx]), 32'(exp[7:0]));
        check("cout", 32'(cout[idx]), 32'(exp[8]));

        // DONE under backpressure: the result and flags must hold.
        hold_ok = 1'b1;
        for (int i = 0; i < stall; i++) begin
            tick();
            if (!out_valid[idx] || in_ready[idx] || busy[idx] ||
                sum[idx] !== exp[7:0] || cout[idx] !== exp[8]) hold_ok = 1'b0;
        end
        check("done_hold", 32'(hold_ok), 32'd1);

        // Handoff edge, then IDLE. The result registers keep their value.
        out_ready[idx] = 1'b1;
        tick();
        out_ready[idx] = 1'b0;
        a[idx] = 8'($urandom); b[idx] = 8'($urandom);
        check("post_out_valid", 32'(out_valid[idx]), 32'd0);
        check("post_in_ready", 32'(in_ready[idx]), 32'd1);
        tick();
        check("idle_sum_kept", {23'd0, cout[idx], sum[idx]}, {23'd0, exp});
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            in_valid[i] = 1'b0; out_ready[i] = 1'b0;
            a[i] = '0; b[i] = '0; cin[i] = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
            sub[i] = 1'b0;
`endif
        end

        // Reset with in_valid and out_ready high. Nothing may be accepted.
        rst_n = 1'b0;
        in_valid[0] = 1'b1; in_valid[1] = 1'b1;
        out_ready[0] = 1'b1; out_ready[1] = 1'b1;
        a[0] = 8'hAA; b[0] = 8'h55;
        repeat (3) tick();
        rst_n = 1'b1;
        in_valid[0] = 1'b0; in_valid[1] = 1'b0;
        out_ready[0] = 1'b0; out_ready[1] = 1'b0;
        tick();
        for (int i = 0; i < 2; i++) begin
            check("rst_in_ready", 32'(in_ready[i]), 32'd1);
            check("rst_busy", 32'(busy[i]), 32'd0);
            check("rst_out_valid", 32'(out_valid[i]), 32'd0);
            check("rst_result", {23'd0, cout[i], sum[i]}, 32'd0);
        end

        // Directed cases.
        do_op(0, 8'hFF, 8'h01, 1'b0, 1'b0, 0);   // 0x100: carry out, sum 0
        do_op(0, 8'h5A, 8'h33, 1'b1, 1'b0, 2);   // 0x08E
        do_op(1, 8'hFF, 8'hFF, 1'b1, 1'b0, 0);   // wrap: 0x1FF
        do_op(0, 8'hFF, 8'hFF, 1'b1, 1'b0, 5);   // wrap on DIGIT=1, 5-cycle stall
        do_op(1, 8'h00, 8'h00, 1'b0, 1'b0, 5);
`ifdef SERIAL_ADDER_SUB_EN
        do_op(0, 8'h05, 8'h07, 1'b0, 1'b1, 1);   // borrow: 0x0FE
        do_op(0, 8'h07, 8'h05, 1'b1, 1'b1, 1);   // 0x102, cin ignored
        do_op(1, 8'h05, 8'h07, 1'b1, 1'b1, 0);
`endif

        // Mid-RUN reset on the 4th RUN cycle, with out_ready and in_valid high.
        a[0] = 8'h12; b[0] = 8'h34; cin[0] = 1'b1; in_valid[0] = 1'b1;
        tick();                       // accept edge
        in_valid[0] = 1'b0;
        repeat (3) tick();            // three RUN edges processed
        rst_n = 1'b0;
        in_valid[0] = 1'b1;
        out_ready[0] = 1'b1;
        tick();                       // 4th RUN edge: reset wins
        rst_n = 1'b1;
        in_valid[0] = 1'b0;
        out_ready[0] = 1'b0;
        check("midrst_in_ready", 32'(in_ready[0]), 32'd1);
        check("midrst_busy", 32'(busy[0]), 32'd0);
        check("midrst_result", {23'd0, cout[0], sum[0]}, 32'd0);
        begin
            bit never_valid;
            never_valid = 1'b1;
            for (int i = 0; i < 12; i++) begin
                if (out_valid[0] || busy[0]) never_valid = 1'b0;
                tick();
            end
            check("midrst_no_out_valid", 32'(never_valid), 32'd1);
        end

        // Random operands on both instances.
        for (int k = 0; k < 30; k++) begin
            for (int idx = 0; idx < 2; idx++) begin
                logic sv;
`ifdef SERIAL_ADDER_SUB_EN
                sv = 1'($urandom);
`else
                sv = 1'b0;
`endif
                do_op(idx, 8'($urandom), 8'($urandom), 1'($urandom), sv,
                      int'($urandom_range(0, 3)));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
